// File: rtl/y_serial_adder_pkg.sv
// Shared definitions for the digit-serial add/subtract unit: FSM states and
// elaboration-time sizing helpers.
package y_serial_adder_pkg;

  typedef enum logic [1:0] {
    Y_IDLE = 2'd0,
    Y_RUN  = 2'd1,
    Y_DONE = 2'd2
  } y_state_t;

  function automatic int steps_of(input int width, input int digit);
    return width / digit;
  endfunction

  // A single-step operation still needs a 1-bit counter to keep the ports legal.
  function automatic int cnt_width(input int steps);
    return (steps <= 1) ? 1 : $clog2(steps);
  endfunction

endpackage

// File: rtl/y_serial_adder_slice.sv
// Combinational DIGIT-bit ripple made of 1-bit full adders; also exposes the
// carry entering the top bit so the caller can derive signed overflow.
module y_serial_adder_slice #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  output logic [DIGIT-1:0] sum,
  output logic             cout,
  output logic             c_msb
);

  always_comb begin
    logic c;
    c     = cin;
    c_msb = cin;
    sum   = '0;
    for (int i = 0; i < DIGIT; i++) begin
      if (i == DIGIT - 1) c_msb = c;
      sum[i] = a[i] ^ b[i] ^ c;
      c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    cout = c;
  end

endmodule

// File: rtl/y_serial_adder.sv
// Digit-serial add/subtract: DIGIT bits per clock through a ripple slice,
// result, carry-out and signed overflow published with a one-cycle done pulse.
module y_serial_adder
  import y_serial_adder_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] z,
  output logic             cout,
  output logic             ovf
);

  if (DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_params
    $error("y_serial_adder: DIGIT must divide WIDTH and lie in 1..WIDTH");
  end

  localparam int STEPS = steps_of(WIDTH, DIGIT);
  localparam int CW    = cnt_width(STEPS);
  localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

  y_state_t         state, state_next;
  logic [WIDTH-1:0] opa, opb, acc, acc_next;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic [DIGIT-1:0] slice_sum;
  logic             slice_cout, slice_cmsb;
  logic             launch;

  // start is only honoured outside RUN, so an operation in flight is never disturbed.
  assign launch = (state != Y_RUN) && start;

  y_serial_adder_slice #(.DIGIT(DIGIT)) u_slice (
    .a    (opa[DIGIT-1:0]),
    .b    (opb[DIGIT-1:0]),
    .cin  (carry),
    .sum  (slice_sum),
    .cout (slice_cout),
    .c_msb(slice_cmsb)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= Y_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      Y_IDLE: if (start) state_next = Y_RUN;
      Y_RUN: begin
        busy = 1'b1;
        if (cnt == LAST) state_next = Y_DONE;
      end
      Y_DONE: begin
        done       = 1'b1;
        state_next = start ? Y_RUN : Y_IDLE;
      end
      default: state_next = Y_IDLE;
    endcase
  end

  // Digit k of the result lands at bit k*DIGIT, i.e. filled LSB-digit first.
  always_comb begin
    acc_next = acc;
    acc_next[int'(cnt)*DIGIT +: DIGIT] = slice_sum;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      opa   <= '0;
      opb   <= '0;
      acc   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      z     <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else if (launch) begin
      opa   <= a;
      opb   <= sub ? ~b : b;
      carry <= sub ? ~cin : cin;
      cnt   <= '0;
    end else if (state == Y_RUN) begin
      opa   <= opa >> DIGIT;
      opb   <= opb >> DIGIT;
      acc   <= acc_next;
      carry <= slice_cout;
      cnt   <= cnt + CW'(1);
      if (cnt == LAST) begin
        z    <= acc_next;
        cout <= slice_cout;
        ovf  <= slice_cmsb ^ slice_cout;
      end
    end
  end

endmodule
